// File: rtl/key_pkg.sv
// key_pkg: shared state encodings, default stability length and counter width for key_debouncer.
package key_pkg;
    localparam int KEY_CNT_W        = 8;
    localparam int KEY_STABLE_TICKS = 5;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;
endpackage

// File: rtl/key_sync2.sv
// key_sync2: two-flop synchronizer for the raw key level, flops clear on reset.
module key_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clock or negedge reset)
        if (!reset) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: push-button debouncer, level accepted after STABLE_TICKS stable clken ticks.
// Define KEY_SYNC_EN to pass keyraw through a two-flop synchronizer first.
module key_debouncer
    import key_pkg::*;
#(
    parameter int STABLE_TICKS = KEY_STABLE_TICKS
) (
    input  logic clock,
    input  logic reset,
    input  logic clken,
    input  logic keyraw,
    output logic keyout,
    output logic keypress
);
    localparam logic [KEY_CNT_W-1:0] LAST = KEY_CNT_W'(STABLE_TICKS - 1);
    logic ks;
`ifdef KEY_SYNC_EN
    key_sync2 u_sync (.clock(clock), .reset(reset), .d(keyraw), .q(ks));
`else
    assign ks = keyraw;
`endif
    key_state_t state, state_nx;
    logic [KEY_CNT_W-1:0] cnt, cnt_nx;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (ks) begin
                state_nx = PRESS_WAIT;
                cnt_nx   = '0;
            end
            PRESS_WAIT: if (!ks) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (clken) begin
                state_nx = (cnt == LAST) ? PRESSED : PRESS_WAIT;
                cnt_nx   = (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            PRESSED: if (!ks) begin
                state_nx = RELEASE_WAIT;
                cnt_nx   = '0;
            end
            RELEASE_WAIT: if (ks) begin
                state_nx = PRESSED;
                cnt_nx   = '0;
            end else if (clken) begin
                state_nx = (cnt == LAST) ? IDLE : RELEASE_WAIT;
                cnt_nx   = (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            keyout   <= 1'b0;
            keypress <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            keyout   <= (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
            keypress <= (state == PRESS_WAIT) && (state_nx == PRESSED);
        end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed bench with a behavioural debounce model checked every cycle.
module tb_key_debouncer;
    localparam int ST = 5;
`ifdef KEY_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic clock = 1'b0, reset = 1'b1, clken = 1'b0, keyraw = 1'b0;
    logic keyout, keypress;
    int vectors = 0, errs = 0;
    int steps = 0, rise_at = -1, fall_at = -1, npress = 0;
    logic prev_out = 1'b0;

    key_debouncer #(.STABLE_TICKS(ST)) dut (
        .clock(clock), .reset(reset), .clken(clken),
        .keyraw(keyraw), .keyout(keyout), .keypress(keypress)
    );

    always #5 clock = ~clock;

    // Model: the settled level flips once ST clken ticks have been seen after the cycle
    // in which the sampled key first disagreed with it, without any intervening agreement.
    logic m_out = 1'b0, m_press = 1'b0, m_dis = 1'b0, s1 = 1'b0, s2 = 1'b0;
    int   m_seen = 0;
    logic ks_m;
    assign ks_m = (LAT == 2) ? s2 : keyraw;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_out <= 1'b0; m_press <= 1'b0; m_dis <= 1'b0; m_seen <= 0; s1 <= 1'b0; s2 <= 1'b0;
        end else begin
            s1 <= keyraw;
            s2 <= s1;
            m_press <= 1'b0;
            if (ks_m == m_out) m_dis <= 1'b0;
            else if (!m_dis) begin
                m_dis  <= 1'b1;
                m_seen <= 0;
            end else if (clken) begin
                if (m_seen + 1 >= ST) begin
                    m_out   <= ks_m;
                    m_dis   <= 1'b0;
                    m_press <= ks_m;
                end else m_seen <= m_seen + 1;
            end
        end
    end

    always @(negedge clock) begin
        vectors += 1;
        if (keyout !== m_out) begin
            errs += 1;
            $display("FAIL cyc_keyout t=%0t got %b want %b", $time, keyout, m_out);
        end
        vectors += 1;
        if (keypress !== m_press) begin
            errs += 1;
            $display("FAIL cyc_keypress t=%0t got %b want %b", $time, keypress, m_press);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors += 1;
        if (act !== exp) begin
            errs += 1;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic ce, input logic kr);
        clken  = ce;
        keyraw = kr;
        @(posedge clock);
        #1;
        steps += 1;
        if (keyout && !prev_out) rise_at = steps;
        if (!keyout && prev_out) fall_at = steps;
        prev_out = keyout;
        if (keypress) npress += 1;
    endtask

    task automatic tick(input logic kr);
        repeat (3) step(1'b0, kr);
        step(1'b1, kr);
    endtask

    task automatic mark();
        steps = 0; rise_at = -1; fall_at = -1; npress = 0; prev_out = keyout;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_keyout", keyout, 0);
        chk("reset_keypress", keypress, 0);
        reset = 1'b1;
        repeat (2) step(1'b0, 1'b0);
        mark(); repeat (30) tick(1'b1);
        chk("clean_rise", rise_at, 20);
        chk("clean_npress", npress, 1);
        chk("clean_hold", keyout, 1);
        mark(); repeat (10) tick(1'b0);
        chk("release_fall", fall_at, 20);
        chk("release_npress", npress, 0);
        mark();
        for (int i = 0; i < 8; i++) tick(((i / 2) % 2) == 0);
        chk("bounce_quiet", rise_at, -1);
        chk("bounce_npress", npress, 0);
        mark(); repeat (10) tick(1'b1);
        chk("bounce_rise", rise_at, 20);
        chk("bounce_npress_final", npress, 1);
        mark(); repeat (4) tick(1'b0); repeat (5) tick(1'b1);
        chk("glitch_fall", fall_at, -1);
        chk("glitch_npress", npress, 0);
        chk("glitch_keyout", keyout, 1);
        mark(); repeat (6) tick(1'b0);
        chk("glitch_release_fall", fall_at, 20);
        mark(); repeat (30) step(1'b0, 1'b1); repeat (5) step(1'b1, 1'b1);
        chk("noclken_rise", rise_at, 35);
        mark(); repeat (10) step(1'b1, 1'b0);
        chk("fast_fall", fall_at, 6 + LAT);
        mark(); repeat (10) step(1'b1, 1'b1);
        chk("sync_rise", rise_at, 6 + LAT);
        repeat (10) step(1'b1, 1'b0);
        mark(); repeat (4) tick(1'b1); step(1'b0, 1'b0); repeat (6) tick(1'b1);
        chk("reversal_rise", rise_at, 37);
        repeat (6) tick(1'b0);
        repeat (3) tick(1'b1);
        #2 reset = 1'b0;
        #1 chk("rstq_keyout", keyout, 0);
        repeat (2) step(1'b0, 1'b1);
        chk("rstq_hold", keyout, 0);
        #2 reset = 1'b1;
        mark(); repeat (6) tick(1'b1);
        chk("rstq_rise", rise_at, 20);
        #2 reset = 1'b0;
        #1 chk("rstp_keyout", keyout, 0);
        chk("rstp_keypress", keypress, 0);
        step(1'b0, 1'b1);
        #2 reset = 1'b1;
        mark(); repeat (6) tick(1'b1);
        chk("rstp_rise", rise_at, 20);
        chk("rstp_npress", npress, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
